// File: rtl/sparse_mult_e_pkg.sv
// Shared constants and types for the sparse-multiply-by-E receive buffer.
package sparse_mult_e_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_WORDS = 1024;
  localparam int DROP_CNT_W    = 16;

  // Width needed to hold a count from 0 up to and including num_words.
  function automatic int level_w(input int num_words);
    return $clog2(num_words) + 1;
  endfunction

  typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/sparse_mult_e_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Contents are not reset. The read register only updates when a read is
// issued, so a fetched word stays on rd_data_o until the next read.
module sparse_mult_e_sdp_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Synchronous read port; holds its last value when idle.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sparse_mult_e_stream_rx.sv
// Receive buffer for the unstallable valid-only word stream of the
// sparse-multiply-by-E datapath. Words land in a circular RAM and are
// re-presented on a ready/valid output. Words arriving while full are
// dropped and flagged via a sticky overflow bit.
//
// Optional feature macro: SPARSE_MULT_E_RX_DROP_COUNT_EN
//   defined   -> o_drop_count counts dropped words, saturating at 16'hFFFF
//   undefined -> o_drop_count is tied to zero
//
// Output handshake: o_out_valid/o_out_data are held stable until an edge
// where i_out_ready is high; a word is transferred exactly at an edge with
// o_out_valid=1 and i_out_ready=1. i_out_ready is ignored while idle.
//
// Read pipeline: RAM read register (avail_q marks it as holding an unused
// word) feeds the output register. A word written at edge k is read at k+1
// and appears on the output after k+2. Because the RAM read register keeps
// its value when no read is issued, it doubles as the prefetch slot, giving
// one word per cycle under sustained ready.
module sparse_mult_e_stream_rx
  import sparse_mult_e_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int NUM_WORDS = DEF_NUM_WORDS,
  localparam int LVL_W     = level_w(NUM_WORDS),
  localparam int AW        = $clog2(NUM_WORDS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [WIDTH-1:0]      i_in_data,
  input  logic                  i_in_valid,
  output logic [WIDTH-1:0]      o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [LVL_W-1:0]      o_level,
  output logic                  o_overflow,
  input  logic                  i_clear_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_count
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] ram_cnt_q, ram_cnt_d, level_q, level_d;
  logic             avail_q, avail_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] ram_rdata;
  logic             full, wr_en, drop, pop, load, rd_en;

  // Full is judged on the pre-edge level; a same-edge pop does not help.
  assign full  = (level_q == LVL_W'(NUM_WORDS));
  assign wr_en = i_in_valid & ~full;
  assign drop  = i_in_valid & full;
  assign pop   = out_valid_q & i_out_ready;
  assign load  = avail_q & (~out_valid_q | pop);
  assign rd_en = (ram_cnt_q != '0) & (~avail_q | load);

  sparse_mult_e_sdp_ram #(
    .WIDTH(WIDTH),
    .DEPTH(NUM_WORDS)
  ) u_ram (
    .clk_i    (i_clock),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(i_in_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(ram_rdata)
  );

  // Next-state for pointers, occupancy counters, output stage and overflow.
  always_comb begin
    wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    if (wr_en && !rd_en)      ram_cnt_d = ram_cnt_q + LVL_W'(1);
    else if (!wr_en && rd_en) ram_cnt_d = ram_cnt_q - LVL_W'(1);
    level_d     = level_q;
    if (wr_en && !pop)        level_d = level_q + LVL_W'(1);
    else if (!wr_en && pop)   level_d = level_q - LVL_W'(1);
    avail_d     = rd_en ? 1'b1 : (load ? 1'b0 : avail_q);
    out_valid_d = load ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    out_data_d  = load ? ram_rdata : out_data_q;
    ovf_d       = drop ? 1'b1 : (i_clear_overflow ? 1'b0 : ovf_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      level_q     <= '0;
      avail_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      level_q     <= level_d;
      avail_q     <= avail_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef SPARSE_MULT_E_RX_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a drop at the same edge as a clear counts as 1.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (i_clear_overflow)      drop_cnt_d = DROP_CNT_W'(1);
      else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end else if (i_clear_overflow) begin
      drop_cnt_d = '0;
    end
  end

  // Drop counter register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) drop_cnt_q <= '0;
    else            drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_count = drop_cnt_q;
`else
  assign o_drop_count = '0;
`endif

  assign o_out_data  = out_data_q;
  assign o_out_valid = out_valid_q;
  assign o_level     = level_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_sparse_mult_e_stream_rx.sv
// Bench for sparse_mult_e_stream_rx: table-driven short sequence, then
// hand-written fill/drain, backpressure, wrap, async reset and overflow cases.
module tb_sparse_mult_e_stream_rx;

  localparam int W  = 8;
  localparam int NW = 1024;
  localparam int LW = 11;

`ifdef SPARSE_MULT_E_RX_DROP_COUNT_EN
  localparam logic [15:0] EXP_DROP1 = 16'd1;
`else
  localparam logic [15:0] EXP_DROP1 = 16'd0;
`endif

  // ---------------- clock / reset ----------------
  logic          i_clock = 1'b0;
  logic          i_reset_n;
  logic [W-1:0]  i_in_data;
  logic          i_in_valid;
  logic [W-1:0]  o_out_data;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [LW-1:0] o_level;
  logic          o_overflow;
  logic          i_clear_overflow;
  logic [15:0]   o_drop_count;

  always #5 i_clock = ~i_clock;

  sparse_mult_e_stream_rx #(.WIDTH(W), .NUM_WORDS(NW)) dut (
    .i_clock         (i_clock),
    .i_reset_n       (i_reset_n),
    .i_in_data       (i_in_data),
    .i_in_valid      (i_in_valid),
    .o_out_data      (o_out_data),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_level         (o_level),
    .o_overflow      (o_overflow),
    .i_clear_overflow(i_clear_overflow),
    .o_drop_count    (o_drop_count)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge: stability under stall and
  // in-order delivery against the expected queue.
  always @(negedge i_clock) begin
    if (mon_en) begin
      if (hold) begin
        check("hold_valid", {31'd0, o_out_valid}, 32'd1);
        check("hold_data", {24'd0, o_out_data}, {24'd0, hold_data});
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %0h want none", o_out_data);
        end else begin
          check("pop_data", {24'd0, o_out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      hold      = o_out_valid && !i_out_ready;
      hold_data = o_out_data;
    end else begin
      hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    while ((exp_q.size() != 0 || o_level != '0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", {31'd0, (exp_q.size() == 0 && o_level == '0)}, 32'd1);
  endtask

  task automatic fill_full();
    i_out_ready = 1'b0;
    for (int i = 0; i < NW; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = i[7:0];
      exp_q.push_back(i[7:0]);
      tick();
    end
    i_in_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          ready;
    logic          exp_valid;
    logic [W-1:0]  exp_data;
    logic [LW-1:0] exp_level;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Four words back to back, ready high; values are after each edge.
    vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 11'd1};
    vecs[1] = '{1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 11'd2};
    vecs[2] = '{1'b1, 8'h13, 1'b1, 1'b1, 8'h11, 11'd3};
    vecs[3] = '{1'b1, 8'h14, 1'b1, 1'b1, 8'h12, 11'd3};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h13, 11'd2};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h14, 11'd1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 11'd0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 11'd0};

    i_reset_n        = 1'b0;
    i_in_data        = '0;
    i_in_valid       = 1'b0;
    i_out_ready      = 1'b0;
    i_clear_overflow = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, o_out_valid}, 32'd0);
    check("rst_data", {24'd0, o_out_data}, 32'd0);
    check("rst_level", {21'd0, o_level}, 32'd0);
    check("rst_ovf", {31'd0, o_overflow}, 32'd0);
    check("rst_drop", {16'd0, o_drop_count}, 32'd0);
    i_reset_n = 1'b1;
    tick();

    // Test 1: table-driven four-word pass-through.
    foreach (vecs[i]) begin
      i_in_valid  = vecs[i].in_valid;
      i_in_data   = vecs[i].in_data;
      i_out_ready = vecs[i].ready;
      tick();
      check("t1_valid", {31'd0, o_out_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check("t1_data", {24'd0, o_out_data}, {24'd0, vecs[i].exp_data});
      check("t1_level", {21'd0, o_level}, {21'd0, vecs[i].exp_level});
      check("t1_ovf", {31'd0, o_overflow}, 32'd0);
    end

    // Test 2: fill to capacity, one drop, drain in order, then clear.
    mon_en = 1'b1;
    fill_full();
    check("t2_level_full", {21'd0, o_level}, NW);
    check("t2_ovf_before", {31'd0, o_overflow}, 32'd0);
    i_in_valid = 1'b1;
    i_in_data  = 8'hAA;
    tick();
    i_in_valid = 1'b0;
    check("t2_ovf_after", {31'd0, o_overflow}, 32'd1);
    check("t2_drop_cnt", {16'd0, o_drop_count}, {16'd0, EXP_DROP1});
    check("t2_level_after", {21'd0, o_level}, NW);
    drain(3000);
    check("t2_ovf_sticky", {31'd0, o_overflow}, 32'd1);
    i_clear_overflow = 1'b1;
    tick();
    i_clear_overflow = 1'b0;
    check("t2_ovf_cleared", {31'd0, o_overflow}, 32'd0);
    check("t2_drop_cleared", {16'd0, o_drop_count}, 32'd0);

    // Test 3: continuous input, ready toggling every cycle.
    for (int i = 0; i < 300; i++) begin
      i_in_valid  = 1'b1;
      i_in_data   = 8'((i * 7) % 256);
      i_out_ready = i[0];
      exp_q.push_back(8'((i * 7) % 256));
      tick();
    end
    drain(1000);

    // Test 4: 3000 words, one every other cycle, ready high. Each word
    // resides three cycles, so at most two are held at any time.
    i_out_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = i[7:0] ^ 8'h5A;
      exp_q.push_back(i[7:0] ^ 8'h5A);
      tick();
      check("t4_level_le2", {31'd0, o_level <= 11'd2}, 32'd1);
      i_in_valid = 1'b0;
      tick();
      check("t4_level_le2", {31'd0, o_level <= 11'd2}, 32'd1);
    end
    drain(100);
    check("t4_no_drop", {31'd0, o_overflow}, 32'd0);

    // Test 5: async reset with ten words held, then a fresh first word.
    mon_en      = 1'b0;
    i_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = 8'(8'hC0 + i);
      tick();
    end
    i_in_valid = 1'b0;
    tick();
    check("t5_level10", {21'd0, o_level}, 32'd10);
    i_reset_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, o_out_valid}, 32'd0);
    check("t5_rst_level", {21'd0, o_level}, 32'd0);
    #1;
    i_reset_n = 1'b1;
    exp_q.delete();
    i_in_valid = 1'b1;
    i_in_data  = 8'h5C;
    tick();
    i_in_valid = 1'b0;
    check("t5_lat_e0", {31'd0, o_out_valid}, 32'd0);
    tick();
    check("t5_lat_e1", {31'd0, o_out_valid}, 32'd0);
    tick();
    check("t5_lat_e2", {31'd0, o_out_valid}, 32'd1);
    check("t5_data", {24'd0, o_out_data}, 32'h5C);
    check("t5_level", {21'd0, o_level}, 32'd1);
    exp_q.push_back(8'h5C);
    mon_en = 1'b1;
    drain(20);

    // Test 6: drop and clear at the same edge; the drop wins.
    fill_full();
    i_in_valid       = 1'b1;
    i_in_data        = 8'hEE;
    i_clear_overflow = 1'b1;
    tick();
    i_in_valid       = 1'b0;
    i_clear_overflow = 1'b0;
    check("t6_ovf", {31'd0, o_overflow}, 32'd1);
    check("t6_drop_cnt", {16'd0, o_drop_count}, {16'd0, EXP_DROP1});
    check("t6_level", {21'd0, o_level}, NW);
    i_clear_overflow = 1'b1;
    tick();
    i_clear_overflow = 1'b0;
    check("t6_ovf_cleared", {31'd0, o_overflow}, 32'd0);
    check("t6_drop_cleared", {16'd0, o_drop_count}, 32'd0);
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
